line_mem_slave_nch: RTL and testbench
=====================================

Name: line_mem_slave_nch

Overview:
- Parametrised multi-channel line memory slave on the cache-memory bus (addr / byte_en / writedata / read / write / readdata / readdata_valid / waitrequest).
- Successor to the fixed two-channel, zero-wait, 1-cycle line model serving icache/dcache.
- Adds N channels sharing one array, round-robin arbitration, real waitrequest backpressure, byte-enable writes, configurable read latency and periodic stall injection.
- Sits between the core's cache ports and the backing store, in simulation and FPGA builds.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8).
- DATA_W, 128, line width in bits; multiple of 32.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, lines in array; power of 2.
- RD_LAT, 2, cycles from read grant to readdata_valid (1..8).
- WAIT_PERIOD, 0, 0 disables stall injection; N>1 forces a no-grant cycle every Nth cycle.
- INIT_FILE, "", hex file loaded into the array at time 0 if non-empty.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_addr  in  NUM_CH*ADDR_W  per-channel byte address, channel c at [c*ADDR_W +: ADDR_W]
- i_byte_en  in  NUM_CH*DATA_W/8  per-channel write byte enables
- i_writedata  in  NUM_CH*DATA_W  per-channel write line
- i_read  in  NUM_CH  read request
- i_write  in  NUM_CH  write request
- o_readdata  out  NUM_CH*DATA_W  per-channel read line
- o_readdata_valid  out  NUM_CH  one-cycle pulse with o_readdata
- o_waitrequest  out  NUM_CH  request not accepted this cycle; hold request stable

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Line index: addr[LB +: log2(DEPTH)], where LB = log2(DATA_W/8). Higher bits are ignored; addresses wrap modulo DEPTH.
- Request: req[c] = i_read[c] | i_write[c].
  - read and write both high on one channel → treated as a write only; no read response.
- Arbitration: at most one grant per cycle, round-robin.
  - Search starts at rr_ptr, wraps through NUM_CH-1 to 0.
  - On grant to channel g, rr_ptr <= (g+1) mod NUM_CH. No grant → rr_ptr unchanged.
- o_waitrequest[c] = req[c] & ~grant[c], combinational from inputs and state.
  - Channel not requesting → waitrequest 0.
- Write on grant: array[idx] byte b <= writedata byte b where byte_en[b]=1; other bytes unchanged. Takes effect at the grant clock edge.
- Read on grant:
  - array[idx] is sampled at the grant edge into a RD_LAT-stage pipeline with {valid, channel id, data}.
  - Exactly RD_LAT cycles after the grant cycle, o_readdata_valid[id] pulses high for one cycle and o_readdata[id] carries the data.
  - Back-to-back reads on consecutive cycles give consecutive valid pulses.
- Ordering: a read granted the cycle after a write to the same line returns the new data. One grant per cycle, so no same-cycle read/write conflict exists.
- o_readdata[c] holds its last value between valid pulses.
- Stall injection (WAIT_PERIOD>1):
  - Free-running counter 0..WAIT_PERIOD-1.
  - In cycles where count == WAIT_PERIOD-1: no grant; all requesting channels see waitrequest=1; rr_ptr unchanged.
- Reset values:
  - rr_ptr=0, stall counter=0, all pipeline valids=0.
  - o_readdata_valid=0, o_readdata=0; o_waitrequest follows the equation above.
  - Array contents are not reset.
- Reset mid-operation: in-flight reads are discarded; no readdata_valid for any read granted before reset deasserts.
- A channel that drops its request while waitrequest=1 is legal; that request is simply never served.

Test Plan:
- Defaults, ch0 writes 0x00112233_44556677_8899AABB_CCDDEEFF to addr 0x40, all byte_en set; next cycle ch0 reads 0x40 → waitrequest 0 both cycles; valid on ch0 exactly 2 cycles after the read grant with the written line.
- ch1 writes 0xFF.. to line 5 with byte_en=0x000F over prior all-zero data → read returns 0x00..00_FFFFFFFF.
- NUM_CH=3, all three read every cycle → grants in order 0,1,2,0,1,2; each channel sees waitrequest=1 in 2 of every 3 cycles; valids arrive in grant order.
- RD_LAT=4, 5 back-to-back ch0 reads of lines 0..4 → 5 consecutive valid pulses starting 4 cycles after the first grant, data in order.
- WAIT_PERIOD=4, ch0 continuous reads → every 4th cycle waitrequest=1; 3 grants per 4 cycles.
- Assert rst for 1 cycle one cycle after a read grant (RD_LAT=2) → no readdata_valid appears; rr_ptr=0 afterwards; array keeps prior writes.

Source files
------------

// File: rtl/line_mem_slave_nch.sv
// line_mem_slave_nch
//   Multi-channel line memory slave for the cache-memory bus. NUM_CH request
//   channels share one DEPTH x DATA_W array. A round-robin arbiter grants at
//   most one request per cycle. Writes honour per-byte enables. Read data
//   returns RD_LAT cycles after the grant. An optional counter forces a
//   no-grant cycle every WAIT_PERIOD cycles to exercise backpressure.
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   i_addr           per-channel byte address, channel c at [c*ADDR_W +: ADDR_W]
//   i_byte_en        per-channel write byte enables (DATA_W/8 each)
//   i_writedata      per-channel write line
//   i_read/i_write   per-channel request strobes (write wins if both are set)
//   o_readdata       per-channel read line, held between valid pulses
//   o_readdata_valid per-channel one-cycle pulse qualifying o_readdata
//   o_waitrequest    request present but not accepted this cycle
module line_mem_slave_nch #(
    parameter int    NUM_CH      = 2,
    parameter int    DATA_W      = 128,
    parameter int    ADDR_W      = 32,
    parameter int    DEPTH       = 1024,
    parameter int    RD_LAT      = 2,
    parameter int    WAIT_PERIOD = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*ADDR_W-1:0]   i_addr,
    input  logic [NUM_CH*DATA_W/8-1:0] i_byte_en,
    input  logic [NUM_CH*DATA_W-1:0]   i_writedata,
    input  logic [NUM_CH-1:0]          i_read,
    input  logic [NUM_CH-1:0]          i_write,
    output logic [NUM_CH*DATA_W-1:0]   o_readdata,
    output logic [NUM_CH-1:0]          o_readdata_valid,
    output logic [NUM_CH-1:0]          o_waitrequest
);

    localparam int BE_W = DATA_W / 8;
    localparam int LB   = $clog2(BE_W);
    localparam int IW   = $clog2(DEPTH);
    localparam int PW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    // Only the line-index field of each address is decoded; the rest is ignored.
    logic unused_addr;
    assign unused_addr = ^i_addr;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt_oh;
    logic              gnt_vld;
    logic [PW-1:0]     gnt_id;
    logic [PW-1:0]     rr_ptr;
    logic              stall;

    assign req           = i_read | i_write;
    assign o_waitrequest = req & ~gnt_oh;

    generate
        if (WAIT_PERIOD > 1) begin : g_stall
            localparam int CW = $clog2(WAIT_PERIOD);
            logic [CW-1:0] stall_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stall_cnt <= '0;
                end else if (stall_cnt == CW'(WAIT_PERIOD - 1)) begin
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + CW'(1);
                end
            end

            assign stall = (stall_cnt == CW'(WAIT_PERIOD - 1));
        end else begin : g_no_stall
            assign stall = 1'b0;
        end
    endgenerate

    // Round-robin search starting at rr_ptr; no grants while in reset so a
    // request presented during reset cannot touch the array.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_oh  = '0;
        if (!rst && !stall) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!gnt_vld && req[(int'(rr_ptr) + k) % NUM_CH]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = PW'((int'(rr_ptr) + k) % NUM_CH);
                end
            end
        end
        if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
    end

    logic [IW-1:0]     sel_idx;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wd;
    logic              sel_we;
    logic              sel_re;

    always_comb begin
        sel_idx = i_addr[int'(gnt_id)*ADDR_W + LB +: IW];
        sel_be  = i_byte_en[int'(gnt_id)*BE_W +: BE_W];
        sel_wd  = i_writedata[int'(gnt_id)*DATA_W +: DATA_W];
        sel_we  = i_write[gnt_id];
        sel_re  = i_read[gnt_id] & ~i_write[gnt_id];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_vld) begin
            rr_ptr <= (gnt_id == PW'(NUM_CH - 1)) ? '0 : gnt_id + PW'(1);
        end
    end

    // ---- grant edge: byte-masked write into the array ----
    always_ff @(posedge clk) begin
        if (gnt_vld && sel_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) mem[sel_idx][b*8 +: 8] <= sel_wd[b*8 +: 8];
            end
        end
    end

    // ---- grant edge -> stage 0 .. stage RD_LAT-1: read pipeline ----
    logic [RD_LAT-1:0] vld_p;
    logic [PW-1:0]     id_p  [RD_LAT];
    logic [DATA_W-1:0] dat_p [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= gnt_vld & sel_re;
            for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        id_p[0]  <= gnt_id;
        dat_p[0] <= mem[sel_idx];
        for (int s = 1; s < RD_LAT; s++) begin
            id_p[s]  <= id_p[s-1];
            dat_p[s] <= dat_p[s-1];
        end
    end

    // ---- last stage -> channel outputs, with per-channel hold register ----
    logic [DATA_W-1:0] rd_hold [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) rd_hold[c] <= '0;
        end else if (vld_p[RD_LAT-1]) begin
            rd_hold[id_p[RD_LAT-1]] <= dat_p[RD_LAT-1];
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_out
            assign o_readdata_valid[c] = vld_p[RD_LAT-1] && (id_p[RD_LAT-1] == PW'(c));
            assign o_readdata[c*DATA_W +: DATA_W] =
                o_readdata_valid[c] ? dat_p[RD_LAT-1] : rd_hold[c];
        end
    endgenerate

endmodule

// File: tb/tb_line_mem_slave_nch.sv
// Testbench for line_mem_slave_nch: directed sequence followed by random
// traffic, each cycle compared against a transaction-level reference model.
module tb_line_mem_slave_nch;

    localparam int NUM_CH      = 3;
    localparam int DATA_W      = 128;
    localparam int ADDR_W      = 32;
    localparam int DEPTH       = 16;
    localparam int RD_LAT      = 3;
    localparam int WAIT_PERIOD = 5;
    localparam int BE_W        = DATA_W / 8;
    localparam int LB          = $clog2(BE_W);
    localparam int IW          = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*ADDR_W-1:0] i_addr;
    logic [NUM_CH*BE_W-1:0]   i_byte_en;
    logic [NUM_CH*DATA_W-1:0] i_writedata;
    logic [NUM_CH-1:0]        i_read;
    logic [NUM_CH-1:0]        i_write;
    logic [NUM_CH*DATA_W-1:0] o_readdata;
    logic [NUM_CH-1:0]        o_readdata_valid;
    logic [NUM_CH-1:0]        o_waitrequest;

    always #5 clk = ~clk;

    line_mem_slave_nch #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .RD_LAT(RD_LAT), .WAIT_PERIOD(WAIT_PERIOD), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_byte_en(i_byte_en),
        .i_writedata(i_writedata), .i_read(i_read), .i_write(i_write),
        .o_readdata(o_readdata), .o_readdata_valid(o_readdata_valid),
        .o_waitrequest(o_waitrequest)
    );

    // Reference model: array of lines, pending responses with due cycle.
    typedef struct {
        int                due;
        int                ch;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] m_mem  [DEPTH];
    logic [DATA_W-1:0] m_hold [NUM_CH];
    rsp_t              q[$];
    int                m_rr, m_k, m_gnt, cyc;
    bit                m_known;
    int                checks, errors;

    function automatic logic [ADDR_W-1:0] line_addr(input int line);
        logic [ADDR_W-1:0] a;
        a = $urandom;
        a[LB +: IW] = IW'(line);
        return a;
    endfunction

    task automatic set_req(input int c, input bit rd, input bit wr, input int line,
                           input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        i_addr[c*ADDR_W +: ADDR_W]      = line_addr(line);
        i_byte_en[c*BE_W +: BE_W]       = be;
        i_writedata[c*DATA_W +: DATA_W] = d;
        i_read[c]                       = rd;
        i_write[c]                      = wr;
    endtask

    task automatic check_cycle();
        logic [NUM_CH-1:0] req, exp_wr, exp_vld;
        logic [DATA_W-1:0] exp_d [NUM_CH];
        bit                stalled;
        req     = i_read | i_write;
        stalled = (WAIT_PERIOD > 1) && ((m_k % WAIT_PERIOD) == WAIT_PERIOD - 1);
        m_gnt   = -1;
        if (!rst && !stalled) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (m_gnt < 0 && req[(m_rr + k) % NUM_CH]) m_gnt = (m_rr + k) % NUM_CH;
            end
        end
        if (!m_known) return;
        if (!rst) begin
            exp_wr = req;
            if (m_gnt >= 0) exp_wr[m_gnt] = 1'b0;
            checks++;
            assert (o_waitrequest === exp_wr) else begin
                errors++;
                $error("FAIL waitrequest cyc=%0d got %b want %b", cyc, o_waitrequest, exp_wr);
            end
        end
        exp_vld = '0;
        for (int c = 0; c < NUM_CH; c++) exp_d[c] = m_hold[c];
        foreach (q[i]) begin
            if (q[i].due == cyc) begin
                exp_vld[q[i].ch] = 1'b1;
                exp_d[q[i].ch]   = q[i].data;
            end
        end
        checks++;
        assert (o_readdata_valid === exp_vld) else begin
            errors++;
            $error("FAIL readdata_valid cyc=%0d got %b want %b", cyc, o_readdata_valid, exp_vld);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            assert (o_readdata[c*DATA_W +: DATA_W] === exp_d[c]) else begin
                errors++;
                $error("FAIL readdata ch%0d cyc=%0d got %h want %h",
                       c, cyc, o_readdata[c*DATA_W +: DATA_W], exp_d[c]);
            end
        end
    endtask

    task automatic update_model();
        rsp_t keep[$];
        int   line;
        if (rst) begin
            m_rr = 0;
            m_k  = 0;
            q.delete();
            for (int c = 0; c < NUM_CH; c++) m_hold[c] = '0;
            m_known = 1'b1;
        end else begin
            foreach (q[i]) begin
                if (q[i].due == cyc) m_hold[q[i].ch] = q[i].data;
                else keep.push_back(q[i]);
            end
            q = keep;
            if (m_gnt >= 0) begin
                line = int'((i_addr[m_gnt*ADDR_W +: ADDR_W] >> LB) % DEPTH);
                if (i_write[m_gnt]) begin
                    for (int b = 0; b < BE_W; b++) begin
                        if (i_byte_en[m_gnt*BE_W + b])
                            m_mem[line][b*8 +: 8] = i_writedata[m_gnt*DATA_W + b*8 +: 8];
                    end
                end else begin
                    q.push_back('{due: cyc + RD_LAT, ch: m_gnt, data: m_mem[line]});
                end
                m_rr = (m_gnt + 1) % NUM_CH;
            end
            m_k++;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    // Present a request and hold it until the model says it is granted.
    task automatic do_op(input int c, input bit rd, input bit wr, input int line,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d,
                         input string tag);
        bit got;
        got = 1'b0;
        set_req(c, rd, wr, line, be, d);
        for (int n = 0; n < 16 && !got; n++) begin
            step();
            got = (m_gnt == c);
        end
        i_read[c]  = 1'b0;
        i_write[c] = 1'b0;
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL grant_%s got none want ch%0d", tag, c);
        end
    endtask

    task automatic expect_line(input int c, input logic [DATA_W-1:0] want, input string tag);
        checks++;
        assert (o_readdata[c*DATA_W +: DATA_W] === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, o_readdata[c*DATA_W +: DATA_W], want);
        end
    endtask

    localparam logic [DATA_W-1:0] LINE40 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DATA_W-1:0] ONES   = '1;
    localparam logic [DATA_W-1:0] LOW32  = 128'h00000000_00000000_00000000_FFFFFFFF;
    localparam logic [DATA_W-1:0] BOTHD  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        m_rr = 0; m_k = 0; m_gnt = -1; m_known = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_hold[c] = '0;
        rst = 1'b1;
        i_addr = '0; i_byte_en = '0; i_writedata = '0; i_read = '0; i_write = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Fill every line with zeros so later reads have defined contents.
        for (int l = 0; l < DEPTH; l++) do_op(0, 1'b0, 1'b1, l, '1, '0, "init");

        // Full-line write to byte address 0x40 then read it back on ch0.
        do_op(0, 1'b0, 1'b1, 'h40 >> LB, '1, LINE40, "wr40");
        do_op(0, 1'b1, 1'b0, 'h40 >> LB, '0, '0, "rd40");
        repeat (RD_LAT + 1) step();
        expect_line(0, LINE40, "line40");

        // Partial byte-enable write on ch1 over an all-zero line.
        do_op(1, 1'b0, 1'b1, 5, 16'h000F, ONES, "wr5");
        do_op(1, 1'b1, 1'b0, 5, '0, '0, "rd5");
        repeat (RD_LAT + 1) step();
        expect_line(1, LOW32, "line5_partial");

        // Read and write together on ch2: write only, no response.
        do_op(2, 1'b1, 1'b1, 6, '1, BOTHD, "rdwr6");
        repeat (RD_LAT + 1) step();
        do_op(2, 1'b1, 1'b0, 6, '0, '0, "rd6");
        repeat (RD_LAT + 1) step();
        expect_line(2, BOTHD, "line6_rdwr");

        // All channels read every cycle: round-robin rotation.
        for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b1, 1'b0, c + 4, '0, '0);
        repeat (12) step();
        i_read = '0;
        repeat (RD_LAT + 1) step();

        // Back-to-back ch0 reads of lines 0..4.
        for (int l = 0; l < 5; l++) do_op(0, 1'b1, 1'b0, l, '0, '0, "b2b");
        repeat (RD_LAT + 1) step();

        // Reset one cycle after a read grant: response must vanish.
        do_op(0, 1'b1, 1'b0, 'h40 >> LB, '0, '0, "rd_pre_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (RD_LAT + 2) step();
        expect_line(0, '0, "readdata_after_rst");
        for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b1, 1'b0, 'h40 >> LB, '0, '0);
        step();
        i_read = '0;
        repeat (RD_LAT + 1) step();
        expect_line(0, LINE40, "array_kept");

        // Random traffic, with occasional single-cycle resets.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_req(c, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                        $urandom_range(0, DEPTH - 1), BE_W'($urandom),
                        {$urandom, $urandom, $urandom, $urandom});
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        i_read = '0; i_write = '0;
        repeat (RD_LAT + 2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
